// File: rtl/operand_pair_loader_pkg.sv
// Shared types and constants for the operand pair loader that feeds the magnitude comparator.
package operand_pair_loader_pkg;

  localparam int unsigned DefaultK = 20;

  localparam logic SelA = 1'b0;
  localparam logic SelB = 1'b1;

  typedef enum logic [1:0] {
    StWaitA,
    StWaitB,
    StFull
  } state_e;

endpackage

// File: rtl/operand_pair_loader.sv
// Collects tagged A/B operand words from one shared input bus and holds them as a registered pair.
// The pair is held until downstream accepts it. Also flags mis-tagged words and counts pairs.
module operand_pair_loader
  import operand_pair_loader_pkg::*;
#(
  parameter int unsigned K = DefaultK
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [K-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [K-1:0] pair_a,
  output logic [K-1:0] pair_b,
  output logic         pair_valid,
  input  logic         pair_ready,
  output logic         seq_err,
  output logic [7:0]   pair_count
);

  state_e       state_q, state_d;
  logic [K-1:0] pair_a_q, pair_a_d;
  logic [K-1:0] pair_b_q, pair_b_d;
  logic         seq_err_q, seq_err_d;
  logic [7:0]   count_q, count_d;
  logic         in_xfer;
  logic         out_xfer;

  // A full pair only frees the input slot on the cycle it drains.
  assign in_ready = (state_q != StFull) || pair_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = (state_q == StFull) && pair_ready;

  always_comb begin
    state_d   = state_q;
    pair_a_d  = pair_a_q;
    pair_b_d  = pair_b_q;
    seq_err_d = 1'b0;
    count_d   = count_q;
    unique case (state_q)
      StWaitA: begin
        if (in_xfer) begin
          if (in_sel == SelA) begin
            pair_a_d = in_data;
            state_d  = StWaitB;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      StWaitB: begin
        if (in_xfer) begin
          if (in_sel == SelB) begin
            pair_b_d = in_data;
            state_d  = StFull;
          end else begin
            // A repeated A restarts the pair with the newer operand.
            pair_a_d  = in_data;
            seq_err_d = 1'b1;
          end
        end
      end
      StFull: begin
        if (out_xfer) begin
          count_d = count_q + 8'd1;
          state_d = StWaitA;
          if (in_xfer) begin
            if (in_sel == SelA) begin
              pair_a_d = in_data;
              state_d  = StWaitB;
            end else begin
              seq_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StWaitA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StWaitA;
      pair_a_q  <= '0;
      pair_b_q  <= '0;
      seq_err_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      pair_a_q  <= pair_a_d;
      pair_b_q  <= pair_b_d;
      seq_err_q <= seq_err_d;
      count_q   <= count_d;
    end
  end

  assign pair_a     = pair_a_q;
  assign pair_b     = pair_b_q;
  assign pair_valid = (state_q == StFull);
  assign seq_err    = seq_err_q;
  assign pair_count = count_q;

endmodule
